// File: rtl/warp_issue_scheduler_if.sv
// Fetch/issue handshake bundle for warp_issue_scheduler.
// slave = scheduler side, master = fetch/pipeline side.
interface warp_issue_scheduler_if #(
    parameter int NUM_WARP     = 4,
    parameter int NUM_WARP_LOG = 2
);
    logic                      stall_i;
    logic [NUM_WARP_LOG-1:0]   instWarp_i;
    logic                      instPacket0Valid_i;
    logic                      instPacket1Valid_i;
    logic                      flush_i;
    logic [NUM_WARP_LOG-1:0]   flushWarp_i;
    logic                      selectedPacketValid_o;
    logic [NUM_WARP_LOG-1:0]   selectedWarp_o;
    logic                      selectedEntry_o;
    logic [2*NUM_WARP-1:0]     entryValid_o;

    modport master (
        output stall_i, instWarp_i, instPacket0Valid_i, instPacket1Valid_i,
               flush_i, flushWarp_i,
        input  selectedPacketValid_o, selectedWarp_o, selectedEntry_o, entryValid_o
    );

    modport slave (
        input  stall_i, instWarp_i, instPacket0Valid_i, instPacket1Valid_i,
               flush_i, flushWarp_i,
        output selectedPacketValid_o, selectedWarp_o, selectedEntry_o, entryValid_o
    );
endinterface

// File: rtl/warp_issue_scheduler.sv
// Issue-side warp scheduler: tracks a two-entry instruction buffer per warp,
// picks one buffered packet per cycle round-robin, applies a per-warp issue
// hold-off and handles reconvergence/exit flushes.
// Optional: define WARP_ISSUE_GREEDY_EN for greedy-then-round-robin selection
// (the last issued warp keeps priority while it stays eligible).
// NUM_WARP is assumed to equal 2**NUM_WARP_LOG so the search index wraps naturally.
module warp_issue_scheduler #(
    parameter int NUM_WARP     = 4,
    parameter int NUM_WARP_LOG = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int HOLD_W       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    warp_issue_scheduler_if.slave  bus
);

    logic [NUM_WARP-1:0]      v0_q, v0_d;
    logic [NUM_WARP-1:0]      v1_q, v1_d;
    logic [HOLD_W-1:0]        hold_q [NUM_WARP];
    logic [HOLD_W-1:0]        hold_d [NUM_WARP];
    logic [NUM_WARP_LOG-1:0]  last_q, last_d;

    logic [NUM_WARP-1:0]      elig;
    logic                     any_elig;
    logic                     issue;
    logic [NUM_WARP_LOG-1:0]  sel;
    logic [NUM_WARP_LOG-1:0]  rr_idx;
    logic                     sel_entry;

    // A warp may issue when it has a buffered packet, its hold-off has expired
    // and it is not being flushed this cycle.
    always_comb begin
        elig = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            elig[w] = (v0_q[w] | v1_q[w]) & (hold_q[w] == '0)
                    & ~(bus.flush_i & (bus.flushWarp_i == NUM_WARP_LOG'(w)));
        end
    end

    // Round-robin search starting just after the last issued warp.
    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        rr_idx   = '0;
        for (int i = 1; i <= NUM_WARP; i++) begin
            rr_idx = last_q + NUM_WARP_LOG'(i);
            if (!any_elig && elig[rr_idx]) begin
                any_elig = 1'b1;
                sel      = rr_idx;
            end
        end
`ifdef WARP_ISSUE_GREEDY_EN
        if (elig[last_q]) begin
            sel = last_q;
        end
`endif
    end

    assign issue     = any_elig & ~bus.stall_i;
    assign sel_entry = ~v0_q[sel];

    assign bus.selectedPacketValid_o = issue;
    assign bus.selectedWarp_o        = issue ? sel : '0;
    assign bus.selectedEntry_o       = issue & sel_entry;

    // Interleave the buffer valid bits: entry 0 of warp w at 2w, entry 1 at 2w+1.
    always_comb begin
        bus.entryValid_o = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            bus.entryValid_o[2*w]   = v0_q[w];
            bus.entryValid_o[2*w+1] = v1_q[w];
        end
    end

    // Next state; later assignments win so flush > fill > issue-clear.
    always_comb begin
        v0_d   = v0_q;
        v1_d   = v1_q;
        hold_d = hold_q;
        last_d = last_q;
        for (int w = 0; w < NUM_WARP; w++) begin
            if (hold_q[w] != '0) begin
                hold_d[w] = hold_q[w] - HOLD_W'(1);
            end
        end
        if (issue) begin
            if (sel_entry) begin
                v1_d[sel] = 1'b0;
            end else begin
                v0_d[sel] = 1'b0;
            end
            hold_d[sel] = HOLD_W'(HOLD_CYCLES);
            last_d      = sel;
        end
        if (bus.instPacket0Valid_i) begin
            v0_d[bus.instWarp_i] = 1'b1;
        end
        if (bus.instPacket1Valid_i) begin
            v1_d[bus.instWarp_i] = 1'b1;
        end
        if (bus.flush_i) begin
            v0_d[bus.flushWarp_i]   = 1'b0;
            v1_d[bus.flushWarp_i]   = 1'b0;
            hold_d[bus.flushWarp_i] = '0;
        end
    end

    // State registers; a stall freezes everything including the hold counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q   <= '0;
            v1_q   <= '0;
            last_q <= NUM_WARP_LOG'(NUM_WARP - 1);
            for (int w = 0; w < NUM_WARP; w++) begin
                hold_q[w] <= '0;
            end
        end else if (!bus.stall_i) begin
            v0_q   <= v0_d;
            v1_q   <= v1_d;
            last_q <= last_d;
            for (int w = 0; w < NUM_WARP; w++) begin
                hold_q[w] <= hold_d[w];
            end
        end
    end

endmodule
